// File: rtl/eprom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eprom_arb_pkg
// Description : Shared types and constants for the two-client EPROM read
//               arbiter: FSM state encoding, client identifier, bus widths
//               and the default EPROM access time.
// Revision    : 1.0 - initial release
// ============================================================================
package eprom_arb_pkg;

    // EPROM bus widths
    localparam int unsigned c_addr_w = 8;
    localparam int unsigned c_data_w = 8;

    // Wide enough for the largest legal access time (15 clocks)
    localparam int unsigned c_cnt_w = 4;

    // Default number of clocks mr_ is held low per read
    localparam int unsigned c_access_cycles_default = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    typedef enum logic {
        CLIENT0 = 1'b0,
        CLIENT1 = 1'b1
    } client_id_t;

endpackage : eprom_arb_pkg
`default_nettype wire

// File: rtl/eprom_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : eprom_arb_pick
// Description : Combinational winner selection between the two read clients.
//               Build option ARB_ROUND_ROBIN_EN: on a tie the client that was
//               not granted last wins; otherwise client 0 always wins a tie.
// Ports       : req0, req1   - client requests
//               last_grant   - client served by the previous handshake
//               grant        - selected client (only meaningful if a req is high)
// Revision    : 1.0 - initial release
// ============================================================================
module eprom_arb_pick
    import eprom_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  client_id_t last_grant,
    output client_id_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = CLIENT0;
        if (req0 && req1) begin
            // Alternate on contention so neither client can starve the other
            grant = (last_grant == CLIENT0) ? CLIENT1 : CLIENT0;
        end else if (req1) begin
            grant = CLIENT1;
        end
    end
`else
    // Fixed priority: history is irrelevant
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;

    always_comb begin
        grant = CLIENT0;
        if (!req0 && req1) begin
            grant = CLIENT1;
        end
    end
`endif

endmodule : eprom_arb_pick
`default_nettype wire

// File: rtl/eprom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eprom_arbiter
// Description : Arbitrates two 4-phase read clients onto one asynchronous
//               EPROM. A grant drives the address and pulls mr_ low for
//               ACCESS_CYCLES clocks, then samples d7_d0 and acknowledges the
//               winner until it drops its request.
// Build option: ARB_ROUND_ROBIN_EN - round-robin tie break (default: fixed
//               priority to client 0, no grant history kept).
// Parameters  : ACCESS_CYCLES - clocks mr_ is low per read, legal 1..15
// Ports       : clock        - sole clock, rising edge
//               reset        - asynchronous active-high reset
//               req0/req1    - client read requests
//               addr0/addr1  - client read addresses
//               ack0/ack1    - client acknowledges (data valid while high)
//               data         - captured read data shared by both clients
//               addr         - EPROM address
//               mr_          - EPROM read strobe, active low
//               d7_d0        - EPROM data bus
// Revision    : 1.0 - initial release
// ============================================================================
module eprom_arbiter
    import eprom_arb_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = c_access_cycles_default
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic [c_addr_w-1:0] addr0,
    input  logic [c_addr_w-1:0] addr1,
    output logic                ack0,
    output logic                ack1,
    output logic [c_data_w-1:0] data,
    output logic [c_addr_w-1:0] addr,
    output logic                mr_,
    input  logic [c_data_w-1:0] d7_d0
);

    // Counter starts at ACCESS_CYCLES-1 so the strobe spans exactly
    // ACCESS_CYCLES clocks including the grant edge.
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(ACCESS_CYCLES - 1);

    arb_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    client_id_t          r_winner, w_winner_nxt;
    logic [c_addr_w-1:0] r_addr, w_addr_nxt;
    logic [c_data_w-1:0] r_data, w_data_nxt;
    logic                r_mr_n, w_mr_n_nxt;
    logic                r_ack0, w_ack0_nxt;
    logic                r_ack1, w_ack1_nxt;

    client_id_t          w_pick;
    client_id_t          w_last_grant;
    logic                w_winner_req;

    assign w_winner_req = (r_winner == CLIENT1) ? req1 : req0;

`ifdef ARB_ROUND_ROBIN_EN
    client_id_t r_last_grant;

    // History updates only when a handshake completes, so an aborted read
    // (reset) never counts as a grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= CLIENT1;
        end else if (r_state == ACK && !w_winner_req) begin
            r_last_grant <= r_winner;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = CLIENT1;
`endif

    eprom_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (w_last_grant),
        .grant      (w_pick)
    );

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_winner <= CLIENT0;
            r_addr   <= '0;
            r_data   <= '0;
            r_mr_n   <= 1'b1;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_winner <= w_winner_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_mr_n   <= w_mr_n_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_winner_nxt = r_winner;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_mr_n_nxt   = r_mr_n;
        w_ack0_nxt   = r_ack0;
        w_ack1_nxt   = r_ack1;

        case (r_state)
            IDLE: begin
                w_mr_n_nxt = 1'b1;
                w_ack0_nxt = 1'b0;
                w_ack1_nxt = 1'b0;
                if (req0 || req1) begin
                    w_winner_nxt = w_pick;
                    w_addr_nxt   = (w_pick == CLIENT1) ? addr1 : addr0;
                    w_mr_n_nxt   = 1'b0;
                    w_cnt_nxt    = c_cnt_load;
                    w_state_nxt  = READ;
                end
            end

            READ: begin
                // Requests are deliberately ignored here: a dropped req still
                // finishes the read and gets a one-cycle ack from ACK.
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end else begin
                    w_data_nxt  = d7_d0;
                    w_mr_n_nxt  = 1'b1;
                    w_ack0_nxt  = (r_winner == CLIENT0);
                    w_ack1_nxt  = (r_winner == CLIENT1);
                    w_state_nxt = ACK;
                end
            end

            ACK: begin
                if (!w_winner_req) begin
                    w_ack0_nxt  = 1'b0;
                    w_ack1_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_mr_n_nxt  = 1'b1;
                w_ack0_nxt  = 1'b0;
                w_ack1_nxt  = 1'b0;
            end
        endcase
    end

    assign mr_  = r_mr_n;
    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign addr = r_addr;
    assign data = r_data;

endmodule : eprom_arbiter
`default_nettype wire

// File: tb/tb_eprom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eprom_arbiter
// Description : Self-checking bench for eprom_arbiter. Vector table for the
//               basic reads, directed sequences for tie-break, reset mid-read,
//               early request drop and ACCESS_CYCLES=1 back-to-back reads,
//               then random traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eprom_arbiter;

    localparam int AC = 2;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00, d7_d0 = 8'h00;
    logic       ack0, ack1, mr_;
    logic [7:0] data, addr;

    logic       f_req0 = 1'b0, f_req1 = 1'b0;
    logic [7:0] f_addr0 = 8'h00, f_addr1 = 8'h00, f_d = 8'h00;
    logic       f_ack0, f_ack1, f_mr_;
    logic [7:0] f_data, f_addr;

    int n_err = 0;
    int n_chk = 0;

    always #5 clock = ~clock;

    eprom_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .ack0(ack0), .ack1(ack1),
        .data(data), .addr(addr), .mr_(mr_), .d7_d0(d7_d0)
    );

    eprom_arbiter #(.ACCESS_CYCLES(1)) dut_fast (
        .clock(clock), .reset(reset), .req0(f_req0), .req1(f_req1),
        .addr0(f_addr0), .addr1(f_addr1), .ack0(f_ack0), .ack1(f_ack1),
        .data(f_data), .addr(f_addr), .mr_(f_mr_), .d7_d0(f_d)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    // ---------------- transaction-level reference model -----------------
    // A transaction is "active" from its grant edge; t counts edges since
    // the grant. Strobe covers t < AC, ack covers t >= AC until the owner's
    // request is seen low.
    bit         m_active;
    int         m_who, m_t, m_last;
    logic [7:0] m_addr, m_data;

    function automatic void model_reset();
        m_active = 0; m_who = 0; m_t = 0; m_last = 1;
        m_addr = 8'h00; m_data = 8'h00;
    endfunction

    function automatic void model_step(logic r0, logic r1, logic [7:0] a0,
                                       logic [7:0] a1, logic [7:0] d);
        if (!m_active) begin
            if (r0 || r1) begin
                if (r0 && r1) m_who = RR ? (1 - m_last) : 0;
                else          m_who = r1 ? 1 : 0;
                m_active = 1;
                m_t      = 0;
                m_addr   = (m_who == 1) ? a1 : a0;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == AC) begin
                m_data = d;
            end else if (m_t > AC && !((m_who == 1) ? r1 : r0)) begin
                m_active = 0;
                m_last   = m_who;
            end
        end
    endfunction

    // One clock on the main DUT, compared against the model
    task automatic cycle();
        @(posedge clock);
        model_step(req0, req1, addr0, addr1, d7_d0);
        @(negedge clock);
        chk("mr_",  mr_,  !(m_active && m_t < AC));
        chk("ack0", ack0, m_active && m_t >= AC && m_who == 0);
        chk("ack1", ack1, m_active && m_t >= AC && m_who == 1);
        chk("addr", addr, m_addr);
        chk("data", data, m_data);
        chk("ack_excl", ack0 & ack1, 1'b0);
        chk("ack_vs_mr", (ack0 | ack1) & ~mr_, 1'b0);
    endtask

    typedef struct {
        logic       r0, r1;
        logic [7:0] a0, a1, d;
        logic       e_mr_n, e_ack0, e_ack1;
        logic [7:0] e_addr, e_data;
    } vec_t;

    vec_t vt[10];
    int   exp_order[3];

    initial begin
        vt[0] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00};
        vt[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00};
        vt[2] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h3C, 8'hA5};
        vt[3] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h3C, 8'hA5};
        vt[4] = '{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5};
        vt[5] = '{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5};
        vt[6] = '{1'b0, 1'b1, 8'h3C, 8'h77, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h77, 8'hA5};
        vt[7] = '{1'b0, 1'b1, 8'h3C, 8'h77, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h77, 8'hA5};
        vt[8] = '{1'b0, 1'b1, 8'h3C, 8'h77, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h77, 8'h5A};
        vt[9] = '{1'b0, 1'b0, 8'h3C, 8'h77, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h77, 8'h5A};
        if (RR) exp_order = '{0, 1, 0};
        else    exp_order = '{0, 0, 0};

        // ---- reset state (asynchronous, before any clock edge) ----
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_mr_",  mr_,  1'b1);
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_ack1", ack1, 1'b0);
        chk("rst_addr", addr, 8'h00);
        chk("rst_data", data, 8'h00);
        chk("rst_fast_mr_", f_mr_, 1'b1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // ---- vector table: single reads on each client ----
        for (int i = 0; i < 10; i++) begin
            req0 = vt[i].r0; req1 = vt[i].r1;
            addr0 = vt[i].a0; addr1 = vt[i].a1; d7_d0 = vt[i].d;
            cycle();
            chk($sformatf("vec%0d_mr_", i),  mr_,  vt[i].e_mr_n);
            chk($sformatf("vec%0d_ack0", i), ack0, vt[i].e_ack0);
            chk($sformatf("vec%0d_ack1", i), ack1, vt[i].e_ack1);
            chk($sformatf("vec%0d_addr", i), addr, vt[i].e_addr);
            chk($sformatf("vec%0d_data", i), data, vt[i].e_data);
        end

        // ---- tie: both requests held, handshake repeated three times ----
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h20; d7_d0 = 8'h5E;
        for (int g = 0; g < 3; g++) begin
            int who;
            who = -1;
            for (int w = 0; w < 20 && who < 0; w++) begin
                cycle();
                if (ack0) who = 0;
                else if (ack1) who = 1;
            end
            chk($sformatf("tie_grant%0d", g), who, exp_order[g]);
            if (who == 0) req0 = 1'b0;
            else if (who == 1) req1 = 1'b0;
            for (int w = 0; w < 10 && (ack0 || ack1); w++) cycle();
            chk($sformatf("tie_ackclr%0d", g), ack0 | ack1, 1'b0);
            req0 = 1'b1; req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int w = 0; w < 6; w++) cycle();

        // ---- reset one cycle after mr_ falls ----
        req0 = 1'b1; addr0 = 8'hC1; d7_d0 = 8'h33;
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_mr_",  mr_,  1'b1);
        chk("midrst_ack0", ack0, 1'b0);
        chk("midrst_ack1", ack1, 1'b0);
        chk("midrst_addr", addr, 8'h00);
        req0 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        begin
            int acks;
            acks = 0;
            for (int w = 0; w < 6; w++) begin
                cycle();
                if (ack0 || ack1) acks++;
            end
            chk("midrst_no_ack", acks, 0);
        end

        // ---- early drop: req1 falls during READ ----
        req1 = 1'b1; addr1 = 8'h9E; d7_d0 = 8'hC3;
        cycle();
        req1 = 1'b0;
        begin
            int hi;
            hi = 0;
            for (int w = 0; w < 6; w++) begin
                cycle();
                if (ack1) begin
                    hi++;
                    chk("drop_data", data, 8'hC3);
                    chk("drop_addr", addr, 8'h9E);
                end
            end
            chk("drop_ack1_cycles", hi, 1);
            chk("drop_idle_mr_", mr_, 1'b1);
        end

        // ---- ACCESS_CYCLES=1: back-to-back handshakes on client 0 ----
        begin
            int pulses, low_run, edge_n, last_fall, last_grant_edge;
            logic prev_ack, prev_mr;
            pulses = 0; low_run = 0; edge_n = 0; last_fall = -1;
            last_grant_edge = -1; prev_ack = 1'b0; prev_mr = 1'b1;
            f_req0 = 1'b1; f_addr0 = 8'h42; f_d = 8'h99;
            for (int i = 0; i < 60 && pulses < 3; i++) begin
                @(posedge clock);
                @(negedge clock);
                edge_n++;
                if (!f_mr_) low_run++;
                if (f_mr_ && !prev_mr) begin
                    chk("fast_mr_len", low_run, 1);
                    low_run = 0;
                end
                if (!f_mr_ && prev_mr) begin
                    last_grant_edge = edge_n;
                    if (last_fall >= 0) chk("fast_gap", edge_n - last_fall, 1);
                end
                chk("fast_ack1", f_ack1, 1'b0);
                if (f_ack0 && !prev_ack) begin
                    pulses++;
                    chk("fast_latency", edge_n - last_grant_edge, 1);
                    chk("fast_data", f_data, f_d);
                    chk("fast_addr", f_addr, 8'h42);
                    f_req0 = 1'b0;
                    f_d = f_d + 8'h11;
                end
                if (!f_ack0 && prev_ack) begin
                    last_fall = edge_n;
                    f_req0 = 1'b1;
                end
                prev_ack = f_ack0;
                prev_mr  = f_mr_;
            end
            chk("fast_pulses", pulses, 3);
            f_req0 = 1'b0;
        end

        // ---- random traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            if (!req0) begin
                if ($urandom_range(2) == 0) begin req0 = 1'b1; addr0 = 8'($urandom); end
            end else if (ack0) begin
                if ($urandom_range(1) == 0) req0 = 1'b0;
            end else if ($urandom_range(9) == 0) begin
                req0 = 1'b0;
            end
            if (!req1) begin
                if ($urandom_range(2) == 0) begin req1 = 1'b1; addr1 = 8'($urandom); end
            end else if (ack1) begin
                if ($urandom_range(1) == 0) req1 = 1'b0;
            end else if ($urandom_range(9) == 0) begin
                req1 = 1'b0;
            end
            d7_d0 = 8'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_eprom_arbiter
`default_nettype wire

// File: doc/eprom_arbiter.md
EPROM_ARBITER -- requirements
Module: eprom_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, number of clocks mr_ is held low per EPROM read (legal range 1..15).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0, req1  input  1 each  client read requests, 4-phase handshake.
REQ-005 SHALL have ports addr0, addr1  input  8 each  client read addresses, stable while the matching req is high.
REQ-006 SHALL have ports ack0, ack1  output  1 each  client acknowledges; data is valid while ack is high.
REQ-007 SHALL have port data  output  8  read result shared by both clients.
REQ-008 SHALL have port addr  output  8  EPROM address.
REQ-009 SHALL have port mr_  output  1  EPROM memory-read strobe, active low.
REQ-010 SHALL have port d7_d0  input  8  EPROM data bus.

Function
REQ-011 SHALL implement states IDLE, READ and ACK.
REQ-012 IDLE: mr_=1, ack0=ack1=0; on an edge with any req high, pick a winner, register its address on addr, drive mr_=0, load cnt=ACCESS_CYCLES-1, go to READ.
REQ-013 READ: if cnt!=0, decrement cnt; if cnt==0, latch d7_d0 into data, drive mr_=1, set the winner's ack=1, go to ACK.
REQ-014 ACK: hold the winner's ack and data until its req is sampled low; then clear ack, record the winner as last_grant and go to IDLE.
REQ-015 Latency: a req sampled at edge k SHALL give mr_ low from edge k to edge k+ACCESS_CYCLES and ack high after edge k+ACCESS_CYCLES.
REQ-016 SHALL never assert ack0 and ack1 together, and SHALL never assert an ack while mr_ is low.
REQ-017 addr SHALL stay constant from grant until return to IDLE; data SHALL hold its last value outside ACK.
REQ-018 The losing requester SHALL stay pending with no ack; it is served on the first IDLE edge after the winner's handshake completes, so consecutive grants are at least one IDLE cycle apart.
REQ-019 If the winner drops req during READ (protocol violation), the read SHALL still complete, ack SHALL pulse for exactly one cycle, and the block SHALL return to IDLE.
REQ-020 A req rising during READ or ACK SHALL have no effect until IDLE.

Reset
REQ-021 While reset is high: state=IDLE, mr_=1, ack0=ack1=0, addr=0, data=0, cnt=0, last_grant=1, all taking effect asynchronously.
REQ-022 A reset in mid-READ SHALL release mr_ immediately and SHALL discard the read; no ack follows reset release.

Configuration
REQ-023 With macro ARB_ROUND_ROBIN_EN defined: when both reqs are high in IDLE, grant the client that is not last_grant, so client 0 wins the first tie after reset.
REQ-024 Without ARB_ROUND_ROBIN_EN: fixed priority, client 0 always wins a tie; last_grant is not implemented.

Structure
REQ-025 Package eprom_arb_pkg SHALL hold the state enum (IDLE/READ/ACK), the client-id type, the ACCESS_CYCLES default and the 8-bit address/data width constants.
REQ-026 Winner selection SHALL be the sub-module eprom_arb_pick, which is combinational, takes req0, req1 and last_grant, and outputs the grant id.

Verification
REQ-027 Single read: ACCESS_CYCLES=2, req0=1, addr0=0x3C, d7_d0=0xA5 -> addr=0x3C, mr_ low exactly 2 cycles, ack0=1 with data=0xA5; drop req0 -> ack0=0 next edge.
REQ-028 Tie, round-robin build: req0 and req1 rise on the same edge and are held -> client 0 served first, then client 1, then client 0; no overlapping acks.
REQ-029 Tie, fixed-priority build: req0 and req1 held continuously -> only client 0 is granted while it keeps re-requesting.
REQ-030 Reset mid-read: assert reset one cycle after mr_ falls -> mr_=1 and ack0=ack1=0 immediately; no ack after release.
REQ-031 Early drop: req1 falls during READ -> ack1 high for exactly one cycle with the correct data, then IDLE.
REQ-032 ACCESS_CYCLES=1 with back-to-back req0 handshakes -> each mr_ pulse lasts 1 cycle and consecutive grants are separated by one IDLE cycle.
